// File: rtl/avg_arb_pkg.sv
// Shared definitions for the rounded-average arbiter slice.
//   out_state_t     : output register occupancy (EMPTY / FULL)
//   idw()           : requester-id width, max(1, clog2(n))
//   rst_last_grant(): last_grant reset value, chosen so requester 0 wins first
package avg_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int idw(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    function automatic int rst_last_grant(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/avg_round_unit.sv
// Combinational rounded average avg = (a + b + 1) >> 1.
//   a, b : W-bit unsigned operands
//   avg  : W-bit rounded average
// The sum is carried in W+1 bits, so the result can never overflow.
module avg_round_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] avg
);

    function automatic logic [W-1:0] round_avg(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] sum;
        sum = {1'b0, x} + {1'b0, y} + (W+1)'(1);
        return sum[W:1];
    endfunction

    assign avg = round_avg(a, b);

endmodule

// File: rtl/avg_share_arbiter.sv
// Shares one rounded-average datapath among NREQ requesters.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester offer of an operand pair
//   req_a/req_b : packed operands, requester i at [i*W +: W]
//   req_ready   : one-hot grant, pair consumed on valid & ready
//   out_valid   : output register holds a result
//   out_avg     : rounded average of the granted pair
//   out_id      : index of the requester that produced out_avg
//   out_ready   : consumer backpressure
//   done_cnt    : results taken by the consumer, wraps modulo 2^CNT_W
module avg_share_arbiter
    import avg_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int W     = 8,
    parameter  int CNT_W = 16,
    localparam int IDW   = idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_avg,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int RST_LAST_GRANT = rst_last_grant(NREQ);

    out_state_t     state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic           load;
    logic [W-1:0]   a_p0;
    logic [W-1:0]   b_p0;
    logic [W-1:0]   avg_p0;

    // Rotating-priority search starting just after the last accepted grant.
    always_comb begin
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant) + k) % NREQ]) begin
                winner = IDW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    // A pair is taken only when the output register is free or being drained
    // this cycle; reset blocks all grants.
    assign load      = !rst && (|req_valid) && ((state == ST_EMPTY) || out_ready);
    assign req_ready = load ? (NREQ'(1) << winner) : '0;

    // ---- stage p0: operand mux and shared rounding datapath ----
    assign a_p0 = req_a[int'(winner)*W +: W];
    assign b_p0 = req_b[int'(winner)*W +: W];

    avg_round_unit #(
        .W (W)
    ) u_round (
        .a   (a_p0),
        .b   (b_p0),
        .avg (avg_p0)
    );

    // ---- output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            out_avg    <= '0;
            out_id     <= '0;
            done_cnt   <= '0;
            last_grant <= IDW'(RST_LAST_GRANT);
        end else begin
            if ((state == ST_FULL) && out_ready) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (load) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Reload in the same cycle as a drain keeps one result per cycle.
                    if (out_ready && !load) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
            if (load) begin
                out_avg    <= avg_p0;
                out_id     <= winner;
                last_grant <= winner;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

endmodule
